// File: rtl/cpu_pc_alu_ctrl_if.sv
// rtl/cpu_pc_alu_ctrl_if.sv - datapath/control bundle between the PC/ALU/control slice and the rest of the CPU
interface cpu_pc_alu_ctrl_if #(
    parameter int W = 64
);
    logic [31:0]  inst;
    logic [W-1:0] imm64;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] pc;
    logic [W-1:0] alu_result;
    logic         reg_write;
    logic         reg2loc;
    logic         mem_write;
    logic         mem_read;
    logic         mem_to_reg;
    logic         alu_src;
    logic         set_flags;
    logic         br_taken;
    logic [2:0]   alu_op;
    logic         flag_n;
    logic         flag_z;
    logic         flag_v;
    logic         flag_c;

    modport master (
        output inst, imm64, rd1, rd2,
        input  pc, alu_result, reg_write, reg2loc, mem_write, mem_read, mem_to_reg,
               alu_src, set_flags, br_taken, alu_op, flag_n, flag_z, flag_v, flag_c
    );

    modport slave (
        input  inst, imm64, rd1, rd2,
        output pc, alu_result, reg_write, reg2loc, mem_write, mem_read, mem_to_reg,
               alu_src, set_flags, br_taken, alu_op, flag_n, flag_z, flag_v, flag_c
    );
endinterface

// File: rtl/cpu_pc_alu_ctrl.sv
// rtl/cpu_pc_alu_ctrl.sv - LEGv8 single-cycle PC, main decoder, 64-bit ALU and NZVC flags
module cpu_pc_alu_ctrl #(
    parameter int           W        = 64,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_pc_alu_ctrl_if.slave     bus
);
    logic [W-1:0] pc_q;
    logic         n_q, z_q, v_q, c_q;

    logic [10:0]  opcode;
    logic         reg_write_d, reg2loc_d, mem_write_d, mem_read_d, mem_to_reg_d;
    logic         alu_src_d, set_flags_d, br_uncond, br_lt, is_cbz;
    logic [2:0]   alu_op_d;

    logic [W-1:0] b_op, b_eff, result;
    logic [W:0]   sum;
    logic         is_sub, alu_c, alu_v, alu_z, take;

    logic         unused_inst;
    assign unused_inst = ^bus.inst[20:5];

    assign opcode = bus.inst[31:21];

    always_comb begin
        reg_write_d  = 1'b0;
        reg2loc_d    = 1'b0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        set_flags_d  = 1'b0;
        br_uncond    = 1'b0;
        br_lt        = 1'b0;
        is_cbz       = 1'b0;
        alu_op_d     = 3'b000;
        casez (opcode)
            11'b1001000100?: begin alu_op_d = 3'b010; alu_src_d = 1'b1; reg_write_d = 1'b1; end
            11'b10101011000: begin alu_op_d = 3'b010; reg_write_d = 1'b1; set_flags_d = 1'b1; reg2loc_d = 1'b1; end
            11'b11101011000: begin alu_op_d = 3'b011; reg_write_d = 1'b1; set_flags_d = 1'b1; reg2loc_d = 1'b1; end
            11'b11111000010: begin
                alu_op_d = 3'b010; alu_src_d = 1'b1; mem_read_d = 1'b1; mem_to_reg_d = 1'b1; reg_write_d = 1'b1;
            end
            11'b11111000000: begin alu_op_d = 3'b010; alu_src_d = 1'b1; mem_write_d = 1'b1; end
            11'b000101?????: br_uncond = 1'b1;
            // Only the LT condition is implemented; every other B.cond falls through untaken.
            11'b01010100???: br_lt = (bus.inst[4:0] == 5'h0B) && (n_q != v_q);
            11'b10110100???: is_cbz = 1'b1;
            default: ;
        endcase
    end

    assign b_op   = alu_src_d ? bus.imm64 : bus.rd2;
    assign is_sub = (alu_op_d == 3'b011);
    assign b_eff  = is_sub ? ~b_op : b_op;
    assign sum    = {1'b0, bus.rd1} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};

    always_comb begin
        result = '0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case (alu_op_d)
            3'b000: result = b_op;
            3'b010, 3'b011: begin
                result = sum[W-1:0];
                alu_c  = sum[W];
                alu_v  = (bus.rd1[W-1] == b_eff[W-1]) && (sum[W-1] != bus.rd1[W-1]);
            end
            3'b100: result = bus.rd1 & b_op;
            3'b101: result = bus.rd1 | b_op;
            3'b110: result = bus.rd1 ^ b_op;
            default: result = '0;
        endcase
    end

    assign alu_z = (result == '0);
    // Reset suppresses every side effect, including a branch already decoded this cycle.
    assign take  = reset && (br_uncond || br_lt || (is_cbz && alu_z));

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            n_q  <= 1'b0;
            z_q  <= 1'b0;
            v_q  <= 1'b0;
            c_q  <= 1'b0;
        end else begin
            pc_q <= take ? pc_q + (bus.imm64 << 2) : pc_q + W'(4);
            if (set_flags_d) begin
                n_q <= result[W-1];
                z_q <= alu_z;
                v_q <= alu_v;
                c_q <= alu_c;
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.alu_result = result;
    assign bus.reg_write  = reset && reg_write_d;
    assign bus.reg2loc    = reg2loc_d;
    assign bus.mem_write  = reset && mem_write_d;
    assign bus.mem_read   = reset && mem_read_d;
    assign bus.mem_to_reg = mem_to_reg_d;
    assign bus.alu_src    = alu_src_d;
    assign bus.set_flags  = reset && set_flags_d;
    assign bus.br_taken   = take;
    assign bus.alu_op     = alu_op_d;
    assign bus.flag_n     = n_q;
    assign bus.flag_z     = z_q;
    assign bus.flag_v     = v_q;
    assign bus.flag_c     = c_q;
endmodule

// File: tb/tb_cpu_pc_alu_ctrl.sv
// tb/tb_cpu_pc_alu_ctrl.sv - directed-vector bench for cpu_pc_alu_ctrl
module tb_cpu_pc_alu_ctrl;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] ADDI = 32'h9100_0000;
    localparam logic [31:0] ADDS = 32'hAB00_0000;
    localparam logic [31:0] SUBS = 32'hEB00_0000;
    localparam logic [31:0] LDUR = 32'hF840_0000;
    localparam logic [31:0] STUR = 32'hF800_0000;
    localparam logic [31:0] BR   = 32'h1400_0000;
    localparam logic [31:0] BLT  = 32'h5400_000B;
    localparam logic [31:0] CBZ  = 32'hB400_0000;
    localparam logic [31:0] BAD  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    cpu_pc_alu_ctrl_if #(.W(64)) bus ();

    cpu_pc_alu_ctrl #(.W(64), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
        bus.inst  = i;
        bus.rd1   = a;
        bus.rd2   = b;
        bus.imm64 = im;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nzvc();
        return {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c};
    endfunction

    function automatic logic [4:0] enables();
        return {bus.reg_write, bus.mem_write, bus.mem_read, bus.set_flags, bus.br_taken};
    endfunction

    task automatic go40();
        reset = 1'b0;
        drive(NOP, 0, 0, 0);
        tick();
        reset = 1'b1;
        drive(BR, 0, 0, 64'd16);
        tick();
        check("go40_pc", bus.pc, 64'h40);
    endtask

    initial begin
        reset = 1'b0;
        drive(ADDI, 0, 0, 64'd5);
        check("rst_force_rw", {63'd0, bus.reg_write}, 64'd0);
        tick();
        check("rst_pc", bus.pc, 64'h0);
        check("rst_flags", {60'd0, nzvc()}, 64'h0);

        reset = 1'b1;
        drive(NOP, 0, 0, 0);
        check("nop_en", {59'd0, enables()}, 64'h0);
        tick();
        check("pc_4", bus.pc, 64'h4);
        tick();
        check("pc_8", bus.pc, 64'h8);

        drive(ADDI, 0, 64'd9, 64'd5);
        check("addi_res", bus.alu_result, 64'd5);
        check("addi_rw", {63'd0, bus.reg_write}, 64'd1);
        check("addi_src", {63'd0, bus.alu_src}, 64'd1);
        tick();
        check("addi_pc", bus.pc, 64'hC);

        drive(SUBS, 64'd3, 64'd3, 64'd77);
        check("subs_res", bus.alu_result, 64'd0);
        check("subs_sf", {63'd0, bus.set_flags}, 64'd1);
        tick();
        check("subs_eq_nzvc", {60'd0, nzvc()}, 64'b0101);
        check("subs_pc", bus.pc, 64'h10);

        drive(SUBS, 64'd0, 64'd1, 0);
        tick();
        check("subs_neg_nzvc", {60'd0, nzvc()}, 64'b1000);

        drive(SUBS, 64'h8000_0000_0000_0000, 64'd1, 0);
        tick();
        check("subs_ovf_nzvc", {60'd0, nzvc()}, 64'b0011);

        drive(ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        check("adds_ovf_res", bus.alu_result, 64'h8000_0000_0000_0000);
        tick();
        check("adds_ovf_nzvc", {60'd0, nzvc()}, 64'b1010);

        drive(ADDS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        tick();
        check("adds_wrap_nzvc", {60'd0, nzvc()}, 64'b0101);

        go40();
        drive(BR, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        check("b_taken", {63'd0, bus.br_taken}, 64'd1);
        tick();
        check("b_back_pc", bus.pc, 64'h38);

        go40();
        drive(CBZ, 64'd5, 64'd0, 64'd3);
        check("cbz0_taken", {63'd0, bus.br_taken}, 64'd1);
        tick();
        check("cbz0_pc", bus.pc, 64'h4C);

        go40();
        drive(CBZ, 64'd5, 64'd7, 64'd3);
        check("cbz7_taken", {63'd0, bus.br_taken}, 64'd0);
        tick();
        check("cbz7_pc", bus.pc, 64'h44);

        go40();
        drive(SUBS, 64'd0, 64'd1, 0);
        tick();
        drive(BR, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("blt_setup_pc", bus.pc, 64'h40);
        drive(BLT, 0, 0, 64'd4);
        check("blt_taken", {63'd0, bus.br_taken}, 64'd1);
        tick();
        check("blt_taken_pc", bus.pc, 64'h50);

        drive(SUBS, 64'd3, 64'd3, 0);
        tick();
        drive(BR, 0, 0, 64'hFFFF_FFFF_FFFF_FFFB);
        tick();
        check("blt2_setup_pc", bus.pc, 64'h40);
        drive(BLT, 0, 0, 64'd4);
        check("blt_not_taken", {63'd0, bus.br_taken}, 64'd0);
        tick();
        check("blt_nt_pc", bus.pc, 64'h44);

        drive(LDUR, 64'h100, 64'h55, 64'd8);
        check("ldur_addr", bus.alu_result, 64'h108);
        check("ldur_ctl", {59'd0, bus.reg_write, bus.mem_write, bus.mem_read, bus.mem_to_reg, bus.alu_src}, 64'b10111);
        tick();
        drive(STUR, 64'h100, 64'h55, 64'd8);
        check("stur_addr", bus.alu_result, 64'h108);
        check("stur_ctl", {58'd0, bus.reg_write, bus.mem_write, bus.mem_read, bus.mem_to_reg, bus.alu_src, bus.reg2loc}, 64'b010010);
        tick();

        drive(BAD, 64'h3, 64'h4, 64'h5);
        check("bad_en", {59'd0, enables()}, 64'h0);
        check("bad_op", {61'd0, bus.alu_op}, 64'h0);
        tick();

        drive(BR, 0, 0, 64'd16);
        reset = 1'b0;
        #1;
        check("rstb_taken", {63'd0, bus.br_taken}, 64'd0);
        tick();
        check("rstb_pc", bus.pc, 64'h0);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
